// File: rtl/norm_detect_32bit_pkg.sv
// Shared constants for the normalizer: data width, stage count, FSM state
// encodings and MODE encodings. The barrel-shifter wrapper imports the same set.
package norm_detect_32bit_pkg;

  localparam int WIDTH = 32;
  localparam int STEPS = 5;
  localparam int SH_W  = 5;
  localparam int IDX_W = 3;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE = 2'd0;
  localparam state_t ST_STEP = 2'd1;
  localparam state_t ST_DONE = 2'd2;

  localparam logic MODE_UNSIGNED = 1'b0;
  localparam logic MODE_SIGNED   = 1'b1;

  // First stage index: the search starts with the widest stage (k = 16).
  localparam logic [IDX_W-1:0] IDX_FIRST = IDX_W'(STEPS - 1);

  // Stage width for a given stage index: 16, 8, 4, 2, 1.
  function automatic logic [SH_W-1:0] stage_k(input logic [IDX_W-1:0] idx);
    return 5'd1 << idx;
  endfunction

endpackage

// File: rtl/norm_step_32bit.sv
// One binary-search stage of the normalizer. Purely combinational: decides
// whether the top k bits are redundant for the selected mode and provides the
// word shifted left by k (zero fill). The caller decides whether to use it.
module norm_step_32bit
  import norm_detect_32bit_pkg::*;
(
  input  logic [WIDTH-1:0] work,
  input  logic [SH_W-1:0]  k,
  input  logic             mode,
  output logic [WIDTH-1:0] shifted,
  output logic             take
);

  logic [WIDTH-1:0] zero_mask;
  logic [WIDTH-1:0] sign_mask;
  logic [WIDTH-1:0] zero_bits;
  logic [WIDTH-1:0] sign_bits;

  // Unsigned mode looks at the top k bits; signed mode looks at the top k+1
  // bits, since the sign bit itself must survive the shift.
  assign zero_mask = ~({WIDTH{1'b1}} >> k);
  assign sign_mask = ~({WIDTH{1'b1}} >> ({1'b0, k} + 6'd1));
  assign zero_bits = work & zero_mask;
  assign sign_bits = work & sign_mask;

  // The stage shifts when the examined field is all zeros (unsigned) or all
  // equal to the sign bit (signed).
  always_comb begin
    take = 1'b0;
    if (mode == MODE_SIGNED) begin
      take = (sign_bits == '0) || (sign_bits == sign_mask);
    end else begin
      take = (zero_bits == '0);
    end
  end

  assign shifted = work << k;

endmodule

// File: rtl/norm_detect_32bit.sv
// Iterative 32-bit normalizer / shift-amount detector. Accepts an operand on a
// valid/ready handshake, runs five binary-search stages (16, 8, 4, 2, 1), then
// presents the normalized word and the total left shift until consumed.
module norm_detect_32bit
  import norm_detect_32bit_pkg::*;
(
  input  logic             CLK,
  input  logic             RST,
  input  logic             IN_VALID,
  output logic             IN_READY,
  input  logic             MODE,
  input  logic [WIDTH-1:0] D_IN,
  output logic             OUT_VALID,
  input  logic             OUT_READY,
  output logic [WIDTH-1:0] D_OUT,
  output logic [SH_W-1:0]  SH_AMT,
  output logic             ZERO
);

  state_t           state;
  logic [IDX_W-1:0] idx;
  logic [SH_W-1:0]  count;
  logic [WIDTH-1:0] work;
  logic             mode_q;
  logic             in_ready_q;
  logic             out_valid_q;
  logic [WIDTH-1:0] d_out_q;
  logic [SH_W-1:0]  sh_amt_q;
  logic             zero_q;

  logic [SH_W-1:0]  step_k;
  logic [WIDTH-1:0] step_shifted;
  logic             step_take;
  logic [WIDTH-1:0] work_next;
  logic [SH_W-1:0]  count_next;

  assign step_k = stage_k(idx);

  norm_step_32bit u_step (
    .work    (work),
    .k       (step_k),
    .mode    (mode_q),
    .shifted (step_shifted),
    .take    (step_take)
  );

  // Result of the current stage: either keep the word or take the shift.
  always_comb begin
    work_next  = work;
    count_next = count;
    if (step_take) begin
      work_next  = step_shifted;
      count_next = count + step_k;
    end
  end

  // Handshake FSM with registered ready/valid and registered result outputs.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state       <= ST_IDLE;
      idx         <= IDX_FIRST;
      count       <= '0;
      work        <= '0;
      mode_q      <= MODE_UNSIGNED;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      d_out_q     <= '0;
      sh_amt_q    <= '0;
      zero_q      <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (in_ready_q && IN_VALID) begin
            work       <= D_IN;
            mode_q     <= MODE;
            count      <= '0;
            zero_q     <= (D_IN == '0);
            idx        <= IDX_FIRST;
            in_ready_q <= 1'b0;
            state      <= ST_STEP;
          end else begin
            in_ready_q <= 1'b1;
          end
        end
        ST_STEP: begin
          work  <= work_next;
          count <= count_next;
          idx   <= idx - 1'b1;
          if (idx == '0) begin
            d_out_q     <= work_next;
            sh_amt_q    <= count_next;
            out_valid_q <= 1'b1;
            idx         <= IDX_FIRST;
            state       <= ST_DONE;
          end
        end
        ST_DONE: begin
          if (OUT_READY) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state       <= ST_IDLE;
          end
        end
        default: begin
          in_ready_q  <= 1'b0;
          out_valid_q <= 1'b0;
          state       <= ST_IDLE;
        end
      endcase
    end
  end

  assign IN_READY  = in_ready_q;
  assign OUT_VALID = out_valid_q;
  assign D_OUT     = d_out_q;
  assign SH_AMT    = sh_amt_q;
  assign ZERO      = zero_q;

endmodule

// File: tb/tb_norm_detect_32bit.sv
// Self-checking bench for norm_detect_32bit: directed boundary cases, back-pressure,
// reset mid-operation, a throughput burst and randomized operands, all checked
// against a bit-counting reference model.
module tb_norm_detect_32bit;

  logic        CLK = 1'b0;
  logic        RST;
  logic        IN_VALID;
  logic        IN_READY;
  logic        MODE;
  logic [31:0] D_IN;
  logic        OUT_VALID;
  logic        OUT_READY;
  logic [31:0] D_OUT;
  logic [4:0]  SH_AMT;
  logic        ZERO;

  norm_detect_32bit dut (
    .CLK       (CLK),
    .RST       (RST),
    .IN_VALID  (IN_VALID),
    .IN_READY  (IN_READY),
    .MODE      (MODE),
    .D_IN      (D_IN),
    .OUT_VALID (OUT_VALID),
    .OUT_READY (OUT_READY),
    .D_OUT     (D_OUT),
    .SH_AMT    (SH_AMT),
    .ZERO      (ZERO)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [31:0] d;
    logic        m;
    logic [4:0]  sh;
    logic [31:0] dout;
    logic        z;
    int          acc;
  } exp_t;

  exp_t exp_q[$];
  int   n_vec = 0;
  int   n_err = 0;
  int   cyc = 0;
  int   last_acc_cyc = -1;
  int   last_pop_cyc = -1;
  bit   lat_checked = 1'b0;
  bit   tput_mode = 1'b0;

  // Reference: count leading zeros (unsigned) or bits below the sign bit that
  // equal it (signed), capped at 31; the result is the operand shifted by that.
  function automatic void ref_model(input logic [31:0] d, input logic m,
                                    output logic [4:0] sh, output logic [31:0] dout,
                                    output logic z);
    int  n;
    bit  run;
    n   = 0;
    run = 1'b1;
    if (!m) begin
      for (int i = 31; i >= 0; i--) begin
        if (run && d[i] == 1'b0) n++;
        else run = 1'b0;
      end
    end else begin
      for (int i = 30; i >= 0; i--) begin
        if (run && d[i] == d[31]) n++;
        else run = 1'b0;
      end
    end
    if (n > 31) n = 31;
    sh   = 5'(n);
    dout = d << n;
    z    = (d == 32'd0);
  endfunction

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    n_vec++;
    n_err++;
    $display("[TB] FAIL %s: bounded wait expired", name);
  endtask

  // Present one operand and hold it until the DUT accepts it.
  task automatic apply_stimulus(input logic [31:0] d, input logic m);
    int t;
    @(negedge CLK);
    IN_VALID = 1'b1;
    D_IN     = d;
    MODE     = m;
    t = 0;
    while (!IN_READY && t < 50) begin
      @(negedge CLK);
      t++;
    end
    if (t >= 50) fail_now("accept_timeout");
    @(negedge CLK);
    IN_VALID = 1'b0;
    D_IN     = $urandom;
    MODE     = 1'($urandom_range(0, 1));
  endtask

  // Wait for a result, hold it for 'hold' cycles of back-pressure, then consume.
  task automatic collect(input int hold, output logic [31:0] dout, output logic [4:0] sh,
                         output logic z);
    int t;
    t = 0;
    while (!OUT_VALID && t < 20) begin
      @(negedge CLK);
      t++;
    end
    if (t >= 20) fail_now("result_timeout");
    dout = D_OUT;
    sh   = SH_AMT;
    z    = ZERO;
    repeat (hold) begin
      @(negedge CLK);
      check_output("hold_valid", 32'(OUT_VALID), 32'd1);
      check_output("hold_dout", D_OUT, dout);
      check_output("hold_sh", 32'(SH_AMT), 32'(sh));
    end
    OUT_READY = 1'b1;
    @(negedge CLK);
    OUT_READY = 1'b0;
  endtask

  task automatic do_op(input string name, input logic [31:0] d, input logic m, input int hold,
                       input logic [4:0] e_sh, input logic [31:0] e_dout, input logic e_z);
    logic [31:0] dout;
    logic [4:0]  sh;
    logic        z;
    apply_stimulus(d, m);
    collect(hold, dout, sh, z);
    check_output({name, "_sh"}, 32'(sh), 32'(e_sh));
    check_output({name, "_dout"}, dout, e_dout);
    check_output({name, "_zero"}, 32'(z), 32'(e_z));
  endtask

  initial begin
    logic [4:0]  msh;
    logic [31:0] mdout;
    logic        mz;
    logic [31:0] base;
    logic [31:0] rd;
    logic        rm;
    logic [31:0] cd;
    logic [4:0]  csh;
    logic        cz;
    int          s;

    RST       = 1'b1;
    IN_VALID  = 1'b0;
    MODE      = 1'b0;
    D_IN      = 32'd0;
    OUT_READY = 1'b0;

    fork
      // Monitor: track accepts and consumed results at the active edge.
      forever begin
        exp_t e;
        @(posedge CLK);
        cyc++;
        if (RST) begin
          exp_q.delete();
          lat_checked = 1'b0;
        end else begin
          if (OUT_VALID && OUT_READY) begin
            if (exp_q.size() > 0) void'(exp_q.pop_front());
            lat_checked  = 1'b0;
            last_pop_cyc = cyc;
          end
          if (IN_VALID && IN_READY) begin
            ref_model(D_IN, MODE, e.sh, e.dout, e.z);
            e.d   = D_IN;
            e.m   = MODE;
            e.acc = cyc;
            exp_q.push_back(e);
            if (tput_mode && last_acc_cyc >= 0)
              check_output("throughput_spacing", 32'(cyc - last_acc_cyc), 32'd7);
            last_acc_cyc = cyc;
          end
        end
      end
      // Compare: every cycle a result is presented, check it against the model.
      forever begin
        exp_t        e;
        logic [31:0] back;
        @(negedge CLK);
        if (OUT_VALID) begin
          check_output("ready_low_in_done", 32'(IN_READY), 32'd0);
          if (exp_q.size() == 0) begin
            fail_now("spurious_out_valid");
          end else begin
            e = exp_q[0];
            check_output("model_dout", D_OUT, e.dout);
            check_output("model_sh", 32'(SH_AMT), 32'(e.sh));
            check_output("model_zero", 32'(ZERO), 32'(e.z));
            if (e.m) back = 32'($signed(D_OUT) >>> SH_AMT);
            else     back = D_OUT >> SH_AMT;
            check_output("restore", back, e.d);
            if (!lat_checked) begin
              check_output("latency", 32'(cyc - e.acc), 32'd5);
              lat_checked = 1'b1;
            end
          end
        end
      end
      begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
      end
    join_none

    // Pin the reference model with hand-computed cases.
    ref_model(32'h00000001, 1'b0, msh, mdout, mz);
    check_output("pin_u1_sh", 32'(msh), 32'd31);
    check_output("pin_u1_dout", mdout, 32'h80000000);
    ref_model(32'h00F00000, 1'b0, msh, mdout, mz);
    check_output("pin_u_f0_sh", 32'(msh), 32'd8);
    ref_model(32'hFFFF8000, 1'b1, msh, mdout, mz);
    check_output("pin_s_neg_sh", 32'(msh), 32'd16);
    ref_model(32'h00004000, 1'b1, msh, mdout, mz);
    check_output("pin_s_pos_dout", mdout, 32'h40000000);
    ref_model(32'hFFFFFFFF, 1'b1, msh, mdout, mz);
    check_output("pin_s_ones_sh", 32'(msh), 32'd31);
    check_output("pin_s_ones_zero", 32'(mz), 32'd0);

    // Reset state.
    repeat (3) @(negedge CLK);
    check_output("rst_out_valid", 32'(OUT_VALID), 32'd0);
    check_output("rst_in_ready", 32'(IN_READY), 32'd0);
    check_output("rst_dout", D_OUT, 32'd0);
    check_output("rst_sh", 32'(SH_AMT), 32'd0);
    check_output("rst_zero", 32'(ZERO), 32'd0);
    RST = 1'b0;
    @(negedge CLK);
    check_output("ready_after_rst", 32'(IN_READY), 32'd1);

    $display("[TB] directed cases");
    do_op("u_one", 32'h00000001, 1'b0, 0, 5'd31, 32'h80000000, 1'b0);
    do_op("u_f0", 32'h00F00000, 1'b0, 1, 5'd8, 32'hF0000000, 1'b0);
    do_op("u_norm", 32'h80000000, 1'b0, 0, 5'd0, 32'h80000000, 1'b0);
    do_op("s_neg", 32'hFFFF8000, 1'b1, 0, 5'd16, 32'h80000000, 1'b0);
    do_op("s_pos", 32'h00004000, 1'b1, 2, 5'd16, 32'h40000000, 1'b0);
    do_op("u_zero", 32'h00000000, 1'b0, 0, 5'd31, 32'h00000000, 1'b1);
    do_op("s_zero", 32'h00000000, 1'b1, 0, 5'd31, 32'h00000000, 1'b1);
    do_op("s_ones", 32'hFFFFFFFF, 1'b1, 0, 5'd31, 32'h80000000, 1'b0);
    do_op("s_norm", 32'h4000ABCD, 1'b1, 0, 5'd0, 32'h4000ABCD, 1'b0);

    $display("[TB] back-pressure with early IN_VALID");
    apply_stimulus(32'h00F00000, 1'b0);
    s = 0;
    while (!OUT_VALID && s < 20) begin
      @(negedge CLK);
      s++;
    end
    if (s >= 20) fail_now("bp_result_timeout");
    cd       = D_OUT;
    IN_VALID = 1'b1;
    D_IN     = 32'h80000000;
    MODE     = 1'b0;
    repeat (10) begin
      @(negedge CLK);
      check_output("bp_valid", 32'(OUT_VALID), 32'd1);
      check_output("bp_in_ready", 32'(IN_READY), 32'd0);
      check_output("bp_dout", D_OUT, cd);
    end
    OUT_READY = 1'b1;
    @(negedge CLK);
    OUT_READY = 1'b0;
    @(negedge CLK);
    IN_VALID = 1'b0;
    check_output("bp_accept_after_pop", 32'(last_acc_cyc), 32'(last_pop_cyc + 1));
    collect(0, cd, csh, cz);
    check_output("bp_next_sh", 32'(csh), 32'd0);
    check_output("bp_next_dout", cd, 32'h80000000);

    $display("[TB] reset during STEP");
    apply_stimulus(32'h00000001, 1'b0);
    repeat (2) @(negedge CLK);
    RST = 1'b1;
    @(negedge CLK);
    check_output("mid_rst_valid", 32'(OUT_VALID), 32'd0);
    check_output("mid_rst_dout", D_OUT, 32'd0);
    check_output("mid_rst_sh", 32'(SH_AMT), 32'd0);
    check_output("mid_rst_zero", 32'(ZERO), 32'd0);
    check_output("mid_rst_ready", 32'(IN_READY), 32'd0);
    @(negedge CLK);
    check_output("mid_rst_ready2", 32'(IN_READY), 32'd0);
    RST = 1'b0;
    @(negedge CLK);
    check_output("mid_rst_ready_rise", 32'(IN_READY), 32'd1);
    do_op("post_rst", 32'h00012345, 1'b0, 0, 5'd15, 32'h91A28000, 1'b0);

    $display("[TB] throughput burst");
    last_acc_cyc = -1;
    tput_mode    = 1'b1;
    OUT_READY    = 1'b1;
    @(negedge CLK);
    IN_VALID = 1'b1;
    repeat (50) begin
      D_IN = $urandom >> $urandom_range(0, 31);
      MODE = 1'($urandom_range(0, 1));
      @(negedge CLK);
    end
    IN_VALID  = 1'b0;
    tput_mode = 1'b0;
    repeat (10) @(negedge CLK);
    OUT_READY = 1'b0;

    $display("[TB] randomized operands");
    for (int n = 0; n < 80; n++) begin
      base = $urandom;
      s    = $urandom_range(0, 31);
      rm   = 1'($urandom_range(0, 1));
      case ($urandom_range(0, 7))
        0:       rd = 32'd0;
        1:       rd = 32'hFFFFFFFF;
        default: rd = rm ? 32'($signed(base) >>> s) : (base >> s);
      endcase
      apply_stimulus(rd, rm);
      collect($urandom_range(0, 3), cd, csh, cz);
    end

    repeat (3) @(negedge CLK);
    if (exp_q.size() != 0) fail_now("results_left_unconsumed");
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
